// File: rtl/nanorv32_datamem_resp.sv
// rtl/nanorv32_datamem_resp.sv - nanorv32 data memory responder with byte lanes and wait states
// Optional feature macro: NANORV32_DATAMEM_RESP_ERR_EN adds datamem_cpu_err for out-of-range accesses.
module nanorv32_datamem_resp #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_datamem_req,
    input  logic [31:0] cpu_datamem_addr,
    input  logic [31:0] cpu_datamem_wdata,
    input  logic [3:0]  cpu_datamem_bytesel,
    output logic [31:0] datamem_cpu_rdata,
`ifdef NANORV32_DATAMEM_RESP_ERR_EN
    output logic        datamem_cpu_err,
`endif
    output logic        datamem_cpu_ack
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam int         DEPTH  = 1 << DEPTH_LOG2;

    logic [1:0]            r_state;
    logic [3:0]            r_cnt;
    logic                  r_ack;
    logic [31:0]           r_rdata;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [31:0]           r_wdata;
    logic [3:0]            r_bytesel;
    logic [31:0]           r_mem [0:DEPTH-1];

    logic                  w_accept;
    logic                  w_commit;
    logic                  w_wr_ok;
    logic [31:0]           w_rd_data;

    // A new request is taken in IDLE and also in the ack cycle, so a held
    // req yields one access every 2+WAIT_STATES cycles.
    assign w_accept = cpu_datamem_req && ((r_state == S_IDLE) || (r_state == S_ACK));
    // The counter has run out: this edge commits the access and raises ack.
    assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0);

`ifdef NANORV32_DATAMEM_RESP_ERR_EN
    logic r_oor;
    logic r_err;
    logic w_oor;
    logic w_unused_addr;

    assign w_oor         = (cpu_datamem_addr >> (DEPTH_LOG2 + 2)) != 32'd0;
    assign w_unused_addr = ^cpu_datamem_addr[1:0];
    assign w_wr_ok       = !r_oor;
    assign w_rd_data     = r_oor ? 32'hDEADBEEF : r_mem[r_idx];
    assign datamem_cpu_err = r_err;

    // Out-of-range flag travels with the captured transaction; err pulses with ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_oor <= w_oor;
            end
            r_err <= w_commit && r_oor;
        end
    end
`else
    logic w_unused_addr;

    // Upper address bits alias into storage in this build.
    assign w_unused_addr = ^{cpu_datamem_addr[31:DEPTH_LOG2+2], cpu_datamem_addr[1:0]};
    assign w_wr_ok       = 1'b1;
    assign w_rd_data     = r_mem[r_idx];
`endif

    assign datamem_cpu_ack   = r_ack;
    assign datamem_cpu_rdata = r_rdata;

    // Capture the request so later input changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx     <= cpu_datamem_addr[DEPTH_LOG2+1:2];
            r_wdata   <= cpu_datamem_wdata;
            r_bytesel <= cpu_datamem_bytesel;
        end
    end

    // Control FSM: counts wait states, produces the ack pulse and read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE, S_ACK: begin
                    if (cpu_datamem_req) begin
                        r_cnt   <= 4'(WAIT_STATES);
                        r_state <= S_WAIT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                        if (r_bytesel == 4'b0000) begin
                            r_rdata <= w_rd_data;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Byte-lane write on the edge that raises ack; a reset on that edge aborts it.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && (r_bytesel != 4'b0000) && w_wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (r_bytesel[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_nanorv32_datamem_resp.sv
// tb/tb_nanorv32_datamem_resp.sv - directed scoreboard bench for nanorv32_datamem_resp
module tb_nanorv32_datamem_resp;

    localparam int WS [3] = '{0, 3, 5};

    typedef struct {
        bit          rd;
        logic [31:0] data;
        bit          err;
    } exp_t;

    logic        clk;
    logic        rst   [3];
    logic        req   [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  bs    [3];
    logic [31:0] rdata [3];
    logic        ack   [3];
    logic        err   [3];

    exp_t        sb [$];
    logic [31:0] mdl [int];
    int          ntests;
    int          nfail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    nanorv32_datamem_resp #(.DEPTH_LOG2(10), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst[0]), .cpu_datamem_req(req[0]), .cpu_datamem_addr(addr[0]),
        .cpu_datamem_wdata(wdata[0]), .cpu_datamem_bytesel(bs[0]),
        .datamem_cpu_rdata(rdata[0]),
`ifdef NANORV32_DATAMEM_RESP_ERR_EN
        .datamem_cpu_err(err[0]),
`endif
        .datamem_cpu_ack(ack[0])
    );

    nanorv32_datamem_resp #(.DEPTH_LOG2(10), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst[1]), .cpu_datamem_req(req[1]), .cpu_datamem_addr(addr[1]),
        .cpu_datamem_wdata(wdata[1]), .cpu_datamem_bytesel(bs[1]),
        .datamem_cpu_rdata(rdata[1]),
`ifdef NANORV32_DATAMEM_RESP_ERR_EN
        .datamem_cpu_err(err[1]),
`endif
        .datamem_cpu_ack(ack[1])
    );

    nanorv32_datamem_resp #(.DEPTH_LOG2(10), .WAIT_STATES(5)) u_ws5 (
        .clk(clk), .rst(rst[2]), .cpu_datamem_req(req[2]), .cpu_datamem_addr(addr[2]),
        .cpu_datamem_wdata(wdata[2]), .cpu_datamem_bytesel(bs[2]),
        .datamem_cpu_rdata(rdata[2]),
`ifdef NANORV32_DATAMEM_RESP_ERR_EN
        .datamem_cpu_err(err[2]),
`endif
        .datamem_cpu_ack(ack[2])
    );

`ifndef NANORV32_DATAMEM_RESP_ERR_EN
    initial begin
        err[0] = 1'b0;
        err[1] = 1'b0;
        err[2] = 1'b0;
    end
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntests++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic bit is_oor(input logic [31:0] a);
`ifdef NANORV32_DATAMEM_RESP_ERR_EN
        return a[31:12] != 20'd0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    // Drive one access on instance k, predict it, then wait for ack and compare.
    task automatic access(input int k, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] b, input bit drop, input bit perturb, input string tag);
        exp_t        e;
        int          cyc;
        int          key;
        logic [31:0] old;
        req[k]   = 1'b1;
        addr[k]  = a;
        wdata[k] = wd;
        bs[k]    = b;
        key      = k * 1024 + int'(a[11:2]);
        e.rd     = (b == 4'b0000);
        e.err    = is_oor(a);
        e.data   = 32'd0;
        if (e.rd) begin
            e.data = e.err ? 32'hDEADBEEF : (mdl.exists(key) ? mdl[key] : 32'hXXXXXXXX);
        end else if (!e.err) begin
            old      = mdl.exists(key) ? mdl[key] : 32'h00000000;
            mdl[key] = merge(old, wd, b);
        end
        sb.push_back(e);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1 && perturb) addr[k] = a ^ 32'h100;
        end while (ack[k] !== 1'b1 && cyc < 40);
        check({tag, "_ack"}, {31'd0, ack[k]}, 32'd1);
        check({tag, "_lat"}, cyc - 1, 1 + WS[k]);
        e = sb.pop_front();
        if (e.rd) check({tag, "_rdata"}, rdata[k], e.data);
        check({tag, "_err"}, {31'd0, err[k]}, {31'd0, e.err});
        if (drop) begin
            req[k] = 1'b0;
            @(posedge clk);
            #1;
            check({tag, "_ackw"}, {31'd0, ack[k]}, 32'd0);
            check({tag, "_errw"}, {31'd0, err[k]}, 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acks;
        ntests = 0;
        nfail  = 0;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; req[k] = 1'b0; addr[k] = 32'd0; wdata[k] = 32'd0; bs[k] = 4'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_ack%0d", k), {31'd0, ack[k]}, 32'd0);
            check($sformatf("rst_rdata%0d", k), rdata[k], 32'd0);
        end
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        @(posedge clk);
        #1;

        access(0, 32'h10, 32'h11223344, 4'b1111, 1, 0, "wr10");
        access(0, 32'h10, 32'h0, 4'b0000, 1, 0, "rd10");

        access(0, 32'h20, 32'h11223344, 4'b1111, 1, 0, "pre20");
        access(0, 32'h20, 32'hAABBCCDD, 4'b0101, 1, 0, "lane20");
        access(0, 32'h20, 32'h0, 4'b0000, 1, 0, "rd20");
        check("lane_literal", rdata[0], 32'h11BB33DD);
        access(0, 32'h23, 32'h0, 4'b0000, 1, 0, "rd23");

        access(1, 32'h30, 32'hA5A5A5A5, 4'b1111, 1, 0, "ws3_wr30");
        access(1, 32'h130, 32'h5A5A5A5A, 4'b1111, 1, 0, "ws3_wr130");
        access(1, 32'h30, 32'h0, 4'b0000, 1, 1, "ws3_rd30");

        access(0, 32'h0, 32'h01010101, 4'b1111, 0, 0, "b2b_w0");
        access(0, 32'h4, 32'h02020202, 4'b1111, 0, 0, "b2b_w4");
        access(0, 32'h8, 32'h03030303, 4'b1111, 1, 0, "b2b_w8");
        access(0, 32'h0, 32'h0, 4'b0000, 0, 0, "b2b_r0");
        access(0, 32'h4, 32'h0, 4'b0000, 0, 0, "b2b_r4");
        access(0, 32'h8, 32'h0, 4'b0000, 1, 0, "b2b_r8");

        access(2, 32'h40, 32'h55AA55AA, 4'b1111, 1, 0, "ws5_pre40");
        req[2] = 1'b1; addr[2] = 32'h40; wdata[2] = 32'hCAFEF00D; bs[2] = 4'b1111;
        acks = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (ack[2] === 1'b1) acks++;
        end
        rst[2] = 1'b1;
        @(posedge clk);
        #1;
        rst[2] = 1'b0;
        req[2] = 1'b0;
        check("midrst_rdata", rdata[2], 32'd0);
        repeat (10) begin
            @(posedge clk);
            #1;
            if (ack[2] === 1'b1) acks++;
        end
        check("midrst_noack", acks, 0);
        access(2, 32'h40, 32'h0, 4'b0000, 1, 0, "midrst_rd40");

        access(0, 32'h1000, 32'h12345678, 4'b1111, 1, 0, "hi_wr1000");
        access(0, 32'h1000, 32'h0, 4'b0000, 1, 0, "hi_rd1000");
        access(0, 32'h0, 32'h0, 4'b0000, 1, 0, "hi_rd0");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
